// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the valid/ready memory bus; grant registered, completion path combinational.
// Optional forced completion after TIMEOUT_CYCLES stalled BUSY cycles when MEM_ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_fault
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic        last;
    logic        sel;
    logic        busy;
    logic        own_valid;
    logic        timeout;
    logic        done;
    logic        pick;
    logic [31:0] resp_dat;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
`else
    logic [CNT_W-1:0] cnt_unused;
    assign cnt_unused = CNT_W'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        sel       = grant[1];
        busy      = (state == BUSY);
        own_valid = sel ? m1_valid : m0_valid;
`ifdef MEM_ARB_TIMEOUT_EN
        timeout   = busy && own_valid && !s_ready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
        timeout   = 1'b0;
`endif
        done      = busy && (s_ready || timeout);
        // A forced completion never reaches the slave and returns zero data.
        s_valid   = busy && own_valid && !timeout;
        s_addr    = busy ? (sel ? m1_addr  : m0_addr)  : 32'h0;
        s_wdata   = busy ? (sel ? m1_wdata : m0_wdata) : 32'h0;
        s_wstrb   = busy ? (sel ? m1_wstrb : m0_wstrb) : 4'h0;
        resp_dat  = timeout ? 32'h0 : s_rdata;
        m0_ready  = done && !sel;
        m1_ready  = done && sel;
        m0_rdata  = (busy && !sel) ? resp_dat : 32'h0;
        m1_rdata  = (busy && sel)  ? resp_dat : 32'h0;
        timeout_fault = timeout;
        // Simultaneous requests go to the master that was not granted last.
        pick      = (m0_valid && m1_valid) ? !last : m1_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            last  <= 1'b1;
            grant <= 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state <= BUSY;
                        last  <= pick;
                        grant <= pick ? 2'b10 : 2'b01;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                BUSY: begin
                    // Completion, forced completion or master abort all release the bus.
                    if (s_ready || timeout || !own_valid) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; covers MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 when defined.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout_fault;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_fault(timeout_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let combinational paths settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic stuck_ok;
        resetn = 1'b0;
        m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        s_ready = 1'b0; s_rdata = 32'h0;
        #12;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_m0_ready", m0_ready, 1'b0);
        chk("rst_m1_ready", m1_ready, 1'b0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_timeout", timeout_fault, 1'b0);
        cyc();
        resetn = 1'b1;

        // Both masters request continuously: m0, m1, m0, m1 with an idle gap each time.
        m0_valid = 1'b1; m0_addr = 32'h0000_0A00;
        m1_valid = 1'b1; m1_addr = 32'h0000_0B00;
        #1;
        chk("rr_idle_s_valid", s_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_grant", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_s_addr", s_addr, (i % 2 == 0) ? 32'h0000_0A00 : 32'h0000_0B00);
            s_ready = 1'b1; s_rdata = 32'h1000 + i;
            #1;
            chk("rr_m0_ready", m0_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr_m1_ready", m1_ready, (i % 2 == 0) ? 1'b0 : 1'b1);
            cyc();
            s_ready = 1'b0;
            #1;
            chk("rr_gap_s_valid", s_valid, 1'b0);
            chk("rr_gap_grant", grant, 2'b00);
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        cyc();

        // Single master read, slave answers 3 cycles after s_valid rises.
        m0_valid = 1'b0; s_rdata = 32'hDEAD_BEEF;
        m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
        #1;
        chk("rd_s_valid_t0", s_valid, 1'b0);
        cyc();
        chk("rd_s_valid_t1", s_valid, 1'b1);
        chk("rd_grant", grant, 2'b01);
        chk("rd_s_addr", s_addr, 32'h0000_0100);
        cyc();
        chk("rd_m0_ready_early", m0_ready, 1'b0);
        cyc();
        chk("rd_m0_ready_early2", m0_ready, 1'b0);
        cyc();
        s_ready = 1'b1;
        #1;
        chk("rd_m0_ready", m0_ready, 1'b1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m1_ready", m1_ready, 1'b0);
        chk("rd_m1_rdata", m1_rdata, 32'h0);
        cyc();
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        chk("rd_grant_done", grant, 2'b00);
        chk("rd_m0_ready_after", m0_ready, 1'b0);

        // m1 write; m0 arrives mid-transaction and must wait.
        m1_valid = 1'b1; m1_addr = 32'h8000_0010; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
        cyc();
        chk("wr_grant", grant, 2'b10);
        chk("wr_s_addr", s_addr, 32'h8000_0010);
        chk("wr_s_wdata", s_wdata, 32'h1234_5678);
        chk("wr_s_wstrb", s_wstrb, 4'b0011);
        m0_valid = 1'b1; m0_addr = 32'h0000_0200;
        cyc();
        chk("wr_no_preempt", grant, 2'b10);
        chk("wr_s_addr_hold", s_addr, 32'h8000_0010);
        s_ready = 1'b1;
        #1;
        chk("wr_m1_ready", m1_ready, 1'b1);
        chk("wr_m0_ready", m0_ready, 1'b0);
        cyc();
        m1_valid = 1'b0; s_ready = 1'b0;
        #1;
        chk("wr_idle_grant", grant, 2'b00);
        cyc();
        chk("wr_then_m0", grant, 2'b01);

        // m0 aborts in its second BUSY cycle while m1 waits.
        m1_valid = 1'b1; m1_addr = 32'h0000_0300;
        cyc();
        chk("ab_busy", grant, 2'b01);
        m0_valid = 1'b0;
        #1;
        chk("ab_s_valid", s_valid, 1'b0);
        chk("ab_m0_ready", m0_ready, 1'b0);
        cyc();
        chk("ab_idle", grant, 2'b00);
        chk("ab_m0_ready_idle", m0_ready, 1'b0);
        chk("ab_m1_ready_idle", m1_ready, 1'b0);
        cyc();
        chk("ab_m1_grant", grant, 2'b10);

        // Slave never responds to m1.
        s_rdata = 32'hCAFE_F00D;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 2; i <= 15; i++) begin
            cyc();
            chk("to_wait_fault", timeout_fault, 1'b0);
        end
        cyc();
        chk("to_m1_ready", m1_ready, 1'b1);
        chk("to_m1_rdata", m1_rdata, 32'h0);
        chk("to_fault", timeout_fault, 1'b1);
        chk("to_s_valid", s_valid, 1'b0);
        cyc();
        chk("to_fault_clear", timeout_fault, 1'b0);
        chk("to_idle", grant, 2'b00);
        chk("to_m1_ready_clear", m1_ready, 1'b0);
        cyc();
        chk("to_regrant_m1", grant, 2'b10);
`else
        stuck_ok = 1'b1;
        for (int i = 0; i < 110; i++) begin
            cyc();
            if (grant !== 2'b10 || s_valid !== 1'b1 || timeout_fault !== 1'b0 || m1_ready !== 1'b0)
                stuck_ok = 1'b0;
        end
        chk("stall_busy_110", stuck_ok, 1'b1);
        chk("stall_grant", grant, 2'b10);
`endif

        // Asynchronous reset while m1 owns the bus.
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_grant", grant, 2'b00);
        chk("arst_s_valid", s_valid, 1'b0);
        chk("arst_m1_ready", m1_ready, 1'b0);
        m0_valid = 1'b1; m0_addr = 32'h0000_0400;
        m1_valid = 1'b1;
        cyc();
        resetn = 1'b1;
        cyc();
        chk("arst_first_m0", grant, 2'b01);
        chk("arst_s_addr", s_addr, 32'h0000_0400);
        m0_valid = 1'b0; m1_valid = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
